bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arbiter_rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 95 +++++++++
 tb/tb_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared constants and types for the round-robin tristate bus arbiter.
package bus_arbiter_pkg;

    localparam int unsigned BUS_WIDTH        = 12;
    localparam int unsigned DEFAULT_N_REQ    = 4;
    localparam int unsigned DEFAULT_MAX_HOLD = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational circular priority pick: first set req bit at or after rr_ptr.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEFAULT_N_REQ
) (
    input  logic [N_REQ-1:0]                req,
    input  logic [idx_width(N_REQ)-1:0]     rr_ptr,
    output logic                            valid,
    output logic [idx_width(N_REQ)-1:0]     index
);

    localparam int unsigned IW = idx_width(N_REQ);

    int unsigned w_dist;
    int unsigned w_best;

    // Smallest circular distance from rr_ptr wins; ties cannot occur.
    always_comb begin
        valid  = 1'b0;
        index  = '0;
        w_dist = 0;
        w_best = N_REQ;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            w_dist = (j >= 32'(rr_ptr)) ? (j - 32'(rr_ptr)) : (j + N_REQ - 32'(rr_ptr));
            if (req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                valid  = 1'b1;
                index  = IW'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared 12-bit tristate bus with bounded hold and a
// mandatory one-cycle turnaround between owners.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = DEFAULT_N_REQ,
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [N_REQ-1:0]                req,
    output logic [N_REQ-1:0]                grant,
    output logic [N_REQ-1:0]                drive_en,
    output logic [idx_width(N_REQ)-1:0]     owner,
    output logic                            busy
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arb_state_t       r_state;
    logic [IW-1:0]    r_rr_ptr;
    logic [HW-1:0]    r_hold_cnt;

    logic             w_pick_valid;
    logic [IW-1:0]    w_pick_idx;
    logic [N_REQ-1:0] w_pick_onehot;
    logic             w_own_req;
    logic             w_other_req;
    logic             w_hold_max;
    logic             w_release;
    logic [IW-1:0]    w_next_ptr;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (r_rr_ptr),
        .valid  (w_pick_valid),
        .index  (w_pick_idx)
    );

    // grant is one-hot on the owner while in GRANT, so masking with it
    // isolates the owner's request from everyone else's.
    assign w_pick_onehot = N_REQ'(1) << w_pick_idx;
    assign w_own_req     = |(req & grant);
    assign w_other_req   = |(req & ~grant);
    assign w_hold_max    = (32'(r_hold_cnt) == MAX_HOLD);
    assign w_release     = !w_own_req || (w_hold_max && w_other_req);
    assign w_next_ptr    = (32'(owner) == N_REQ - 1) ? '0 : owner + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            grant      <= '0;
            drive_en   <= '0;
            owner      <= '0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, TURNAROUND: begin
                    if (w_pick_valid) begin
                        r_state    <= GRANT;
                        r_hold_cnt <= HW'(1);
                        grant      <= w_pick_onehot;
                        drive_en   <= w_pick_onehot;
                        owner      <= w_pick_idx;
                        busy       <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state    <= TURNAROUND;
                        r_rr_ptr   <= w_next_ptr;
                        r_hold_cnt <= '0;
                        grant      <= '0;
                        drive_en   <= '0;
                        busy       <= 1'b0;
                    end else if (!w_hold_max) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    grant      <= '0;
                    drive_en   <= '0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;
    localparam int WORST_WAIT = (N - 1) * (MH + 1) + 1;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] drive_en;
    logic [1:0] owner;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    int m_owner;
    int m_held;
    int m_ptr;

    always #5 clock = ~clock;

    bus_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .grant    (grant),
        .drive_en (drive_en),
        .owner    (owner),
        .busy     (busy)
    );

    function automatic logic [3:0] m_grant();
        if (m_owner < 0) return 4'b0000;
        return 4'b0001 << m_owner;
    endfunction

    // Reference behaviour: owner keeps the bus until it lets go or has used
    // its full hold while someone else waits; idle/gap cycles pick round-robin.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] others;
        logic [1:0] idx;
        int         pick;
        if (m_owner >= 0) begin
            others = r & ~m_grant();
            if (((r >> m_owner) & 4'b0001) == 4'b0000 || (m_held == MH && others != 4'b0000)) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_held  = 0;
            end else if (m_held < MH) begin
                m_held++;
            end
        end else begin
            pick = -1;
            for (int k = 0; k < N; k++) begin
                idx = 2'((m_ptr + k) % N);
                if (pick < 0 && r[idx]) pick = int'(idx);
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_held  = 1;
            end
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_ptr   = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_edge(req);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        model_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        n_cmp++; if (drive_en !== 4'b0000) begin n_bad++; $display("FAIL reset_drive_en got=%b want=0000", drive_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL idle_no_req got=%b want=0000", grant); end
    endtask

    task automatic test_single();
        req = 4'b0001;
        tick();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant got=%b want=0001", grant); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got=%b want=1", busy); end
        n_cmp++; if (owner !== 2'd0) begin n_bad++; $display("FAIL single_owner got=%0d want=0", owner); end
        repeat (2) tick();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_hold got=%b want=0001", grant); end
        req = 4'b0000;
        tick();
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL single_drop got=%b want=0000", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_drop_busy got=%b want=0", busy); end
    endtask

    task automatic test_rotation();
        logic [3:0] seq[$];
        logic [3:0] exp_seq[7];
        int         cnt[4];
        exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
        cnt = '{0, 0, 0, 0};
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (grant !== m_grant()) begin n_bad++; $display("FAIL rotation_model cyc=%0d got=%b want=%b", c, grant, m_grant()); end
            if (seq.size() == 0 || seq[$] != grant) seq.push_back(grant);
            for (int i = 0; i < 4; i++) begin
                if (grant[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 2) req[i] = 1'b0;
                end
            end
        end
        n_cmp++;
        if (seq.size() < 7) begin
            n_bad++; $display("FAIL rotation_len got=%0d want>=7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                n_cmp++; if (seq[i] !== exp_seq[i]) begin n_bad++; $display("FAIL rotation_seq[%0d] got=%b want=%b", i, seq[i], exp_seq[i]); end
            end
        end
    endtask

    task automatic test_preempt();
        int run;
        do_reset();
        req = 4'b0001;
        repeat (3) tick();
        run = 3;
        req = 4'b0101;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_cmp++; if (grant !== m_grant()) begin n_bad++; $display("FAIL preempt_model cyc=%0d got=%b want=%b", c, grant, m_grant()); end
            if (grant == 4'b0001) run++;
            else break;
        end
        n_cmp++; if (run != MH) begin n_bad++; $display("FAIL preempt_hold got=%0d want=%0d", run, MH); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL preempt_gap got=%b want=0000", grant); end
        tick();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL preempt_next got=%b want=0100", grant); end
    endtask

    task automatic test_hold_alone();
        req = 4'b0000;
        repeat (2) tick();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (grant !== 4'b0001 || busy !== 1'b1) begin n_bad++; $display("FAIL hold_alone cyc=%0d got=%b/%b want=0001/1", c, grant, busy); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010;
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL rstmid_pre got=%b want=0010", grant); end
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rstmid_grant got=%b want=0000", grant); end
        n_cmp++; if (drive_en !== 4'b0000) begin n_bad++; $display("FAIL rstmid_drive_en got=%b want=0000", drive_en); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        @(negedge clock);
        reset_n = 1'b1;
        req = 4'b0110;
        tick();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL rstmid_after got=%b want=0010", grant); end
        n_cmp++; if (owner !== 2'd1) begin n_bad++; $display("FAIL rstmid_owner got=%0d want=1", owner); end
    endtask

    task automatic test_pulse();
        req = 4'b0001;
        for (int c = 0; c < 6 && grant != 4'b0001; c++) tick();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL pulse_setup got=%b want=0001", grant); end
        req = 4'b0011;
        tick();
        req = 4'b0001;
        for (int c = 0; c < 14; c++) begin
            n_cmp++;
            if (grant[1] !== 1'b0 || grant !== drive_en || $countones(grant) > 1 || grant !== m_grant()) begin
                n_bad++; $display("FAIL pulse cyc=%0d got=%b drive_en=%b want=%b", c, grant, drive_en, m_grant());
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [3:0] prev;
        int         waitc[4];
        int         max_wait;
        waitc    = '{0, 0, 0, 0};
        max_wait = 0;
        do_reset();
        prev = 4'b0000;
        req  = 4'($urandom_range(0, 15));
        for (int c = 0; c < 500; c++) begin
            tick();
            n_cmp++;
            if (grant !== m_grant() || drive_en !== m_grant() || busy !== (m_owner >= 0) ||
                (m_owner >= 0 && owner !== 2'(m_owner))) begin
                n_bad++;
                $display("FAIL random_model cyc=%0d got=%b/%b/%b/%0d want=%b/%b/%b/%0d",
                         c, grant, drive_en, busy, owner, m_grant(), m_grant(), (m_owner >= 0), m_owner);
            end
            n_cmp++;
            if ($countones(grant) > 1 || (prev != 4'b0000 && grant != 4'b0000 && grant != prev)) begin
                n_bad++; $display("FAIL random_contention cyc=%0d prev=%b got=%b", c, prev, grant);
            end
            prev = grant;
            for (int i = 0; i < 4; i++) begin
                if (grant[i] || !req[i]) waitc[i] = 0;
                else waitc[i]++;
                if (waitc[i] > max_wait) max_wait = waitc[i];
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
        end
        n_cmp++; if (max_wait > WORST_WAIT) begin n_bad++; $display("FAIL random_wait got=%0d want<=%0d", max_wait, WORST_WAIT); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_hold_alone();
        test_reset_mid();
        test_pulse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
